md_unit: RTL and testbench



---
 rtl/md_unit_pkg.sv | 27 ++
 rtl/md_calc.sv | 70 +++++++
 rtl/md_unit.sv | 90 +++++++++
 tb/tb_md_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit:
// op encodings, default latencies and edge-case results.
package md_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } mdOp_e;

  typedef enum logic {
    IDLE,
    BUSY
  } mdState_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_LO  = 32'h8000_0000;
  localparam logic [31:0] OVF_HI  = 32'h0000_0000;

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit result generator for mult/multu/div/divu,
// including divide-by-zero and signed-overflow results.
module md_calc
  import md_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [63:0] prodS;
  logic [63:0] prodU;
  logic signed [31:0] sa;
  logic signed [31:0] sb;
  logic signed [31:0] qS;
  logic signed [31:0] rS;
  logic [31:0] qU;
  logic [31:0] rU;
  logic bZero;
  logic ovf;

  // Low 64 bits of a sign-extended product equal the signed product.
  assign prodS = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prodU = {32'b0, a} * {32'b0, b};

  assign sa = a;
  assign sb = b;
  assign qS = sa / sb;
  assign rS = sa % sb;
  assign qU = a / b;
  assign rU = a % b;

  assign bZero = (b == 32'd0);
  assign ovf   = (a == 32'h8000_0000) &&
                 (b == 32'hFFFF_FFFF);

  always_comb begin
    hi = '0;
    lo = '0;
    unique case (1'b1)
      op == MD_MULT: {hi, lo} = prodS;
      op == MD_MULTU: {hi, lo} = prodU;
      op == MD_DIV: begin
        if (bZero) begin
          hi = a;
          lo = DIV0_LO;
        end else if (ovf) begin
          hi = OVF_HI;
          lo = OVF_LO;
        end else begin
          hi = rS;
          lo = qS;
        end
      end
      op == MD_DIVU: begin
        if (bZero) begin
          hi = a;
          lo = DIV0_LO;
        end else begin
          hi = rU;
          lo = qU;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit beside the E-stage ALU: owns HI/LO,
// runs fixed-latency mult/div and drives the busy stall flag.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iStart,
  input  logic [2:0]  iMD_op,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  input  logic        iRead_sel,
  output logic        oBusy,
  output logic [31:0] oMDout,
  output logic [31:0] oHI,
  output logic [31:0] oLO
);

  mdState_e state;
  logic [3:0]  cnt;
  logic [31:0] pendHI;
  logic [31:0] pendLO;
  logic [31:0] calcHI;
  logic [31:0] calcLO;
  logic isMul;
  logic isDiv;

  md_calc uCalc (
    .op (iMD_op),
    .a  (iA),
    .b  (iB),
    .hi (calcHI),
    .lo (calcLO)
  );

  assign isMul = (iMD_op == MD_MULT) ||
                 (iMD_op == MD_MULTU);
  assign isDiv = (iMD_op == MD_DIV) ||
                 (iMD_op == MD_DIVU);

  assign oMDout = iRead_sel ? oHI : oLO;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      oBusy  <= 1'b0;
      cnt    <= '0;
      pendHI <= '0;
      pendLO <= '0;
      oHI    <= '0;
      oLO    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (iStart && (isMul || isDiv)) begin
            pendHI <= calcHI;
            pendLO <= calcLO;
            cnt    <= isMul ? 4'(MULT_CYCLES)
                            : 4'(DIV_CYCLES);
            state  <= BUSY;
            oBusy  <= 1'b1;
          end else if (iStart &&
                       iMD_op == MD_MTHI) begin
            oHI <= iA;
          end else if (iStart &&
                       iMD_op == MD_MTLO) begin
            oLO <= iA;
          end
        end
        BUSY: begin
          // Starts arriving here are stall violations; drop them.
          if (cnt == 4'd1) begin
            oHI   <= pendHI;
            oLO   <= pendLO;
            cnt   <= '0;
            state <= IDLE;
            oBusy <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit:
// latency, arithmetic edge cases, mthi/mtlo and reset.
module tb_md_unit;
  import md_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        iStart;
  logic [2:0]  iMD_op;
  logic [31:0] iA;
  logic [31:0] iB;
  logic        iRead_sel;
  logic        oBusy;
  logic [31:0] oMDout;
  logic [31:0] oHI;
  logic [31:0] oLO;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  md_unit #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .iStart    (iStart),
    .iMD_op    (iMD_op),
    .iA        (iA),
    .iB        (iB),
    .iRead_sel (iRead_sel),
    .oBusy     (oBusy),
    .oMDout    (oMDout),
    .oHI       (oHI),
    .oLO       (oLO)
  );

  task automatic test_reset;
    // Give HI a value, then pull reset between clock edges.
    @(negedge clk);
    iStart = 1'b1; iMD_op = MD_MTHI; iA = 32'hDEAD_BEEF;
    @(negedge clk);
    iStart = 1'b0; iMD_op = MD_NONE;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (oHI !== 32'h0 || oLO !== 32'h0 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got HI=%h LO=%h busy=%b want 0/0/0",
               oHI, oLO, oBusy);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (oHI !== 32'h0 || oLO !== 32'h0 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got HI=%h LO=%h busy=%b want 0/0/0",
               oHI, oLO, oBusy);
    end
  endtask

  task automatic test_arith(input string tag, input int n,
                            input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eHi, input logic [31:0] eLo);
    @(negedge clk);
    iStart = 1'b1; iMD_op = op; iA = a; iB = b;
    @(negedge clk);
    iStart = 1'b0; iMD_op = MD_NONE;
    for (int c = 1; c <= n; c++) begin
      checks++;
      if (oBusy !== 1'b1) begin
        errors++;
        $display("FAIL %s_busy cycle %0d got %b want 1", tag, c, oBusy);
      end
      @(negedge clk);
    end
    checks++;
    if (oBusy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done got busy=%b want 0", tag, oBusy);
    end
    checks++;
    if (oHI !== eHi || oLO !== eLo) begin
      errors++;
      $display("FAIL %s_result got HI=%h LO=%h want HI=%h LO=%h",
               tag, oHI, oLO, eHi, eLo);
    end
  endtask

  task automatic test_mult;
    test_arith("mult", 5, MD_MULT, 32'hFFFF_FFFE, 32'd3,
               32'hFFFF_FFFF, 32'hFFFF_FFFA);
    test_arith("multu", 5, MD_MULTU, 32'hFFFF_FFFE, 32'd3,
               32'h0000_0002, 32'hFFFF_FFFA);
  endtask

  task automatic test_div;
    test_arith("div", 10, MD_DIV, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
    test_arith("divu0", 10, MD_DIVU, 32'd7, 32'd0,
               32'h0000_0007, 32'hFFFF_FFFF);
    test_arith("divovf", 10, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h8000_0000);
    test_arith("divu", 10, MD_DIVU, 32'd100, 32'd7,
               32'h0000_0002, 32'h0000_000E);
    test_arith("div0", 10, MD_DIV, 32'hFFFF_FFFB, 32'd0,
               32'hFFFF_FFFB, 32'hFFFF_FFFF);
  endtask

  task automatic test_mthi_mtlo;
    @(negedge clk);
    iStart = 1'b1; iMD_op = MD_MTHI; iA = 32'h1234_5678;
    @(negedge clk);
    iStart = 1'b1; iMD_op = MD_MTLO; iA = 32'h9ABC_DEF0;
    checks++;
    if (oHI !== 32'h1234_5678 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL mthi got HI=%h busy=%b want 12345678/0", oHI, oBusy);
    end
    @(negedge clk);
    iStart = 1'b1; iMD_op = 3'd7; iA = 32'h5555_5555; iB = 32'h3;
    checks++;
    if (oLO !== 32'h9ABC_DEF0 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL mtlo got LO=%h busy=%b want 9abcdef0/0", oLO, oBusy);
    end
    @(negedge clk);
    iStart = 1'b0; iMD_op = MD_NONE;
    iRead_sel = 1'b1;
    #1;
    checks++;
    if (oMDout !== 32'h1234_5678 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL mdout_hi/op7 got %h busy=%b want 12345678/0",
               oMDout, oBusy);
    end
    iRead_sel = 1'b0;
    #1;
    checks++;
    if (oMDout !== 32'h9ABC_DEF0) begin
      errors++;
      $display("FAIL mdout_lo got %h want 9abcdef0", oMDout);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    iStart = 1'b1; iMD_op = MD_DIV; iA = 32'hFFFF_FFF9; iB = 32'd2;
    @(negedge clk);
    iStart = 1'b0; iMD_op = MD_NONE;
    for (int c = 1; c <= 10; c++) begin
      checks++;
      if (oBusy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_busy cycle %0d got %b want 1", c, oBusy);
      end
      if (c == 2) begin
        iStart = 1'b1; iMD_op = MD_MULT; iA = 32'd3; iB = 32'd4;
      end else begin
        iStart = 1'b0; iMD_op = MD_NONE;
      end
      @(negedge clk);
    end
    checks++;
    if (oBusy !== 1'b0 || oHI !== 32'hFFFF_FFFF || oLO !== 32'hFFFF_FFFD)
    begin
      errors++;
      $display("FAIL b2b_result got busy=%b HI=%h LO=%h want 0/ffffffff/fffffffd",
               oBusy, oHI, oLO);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (oBusy !== 1'b0 || oLO !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL b2b_late got busy=%b LO=%h want 0/fffffffd",
               oBusy, oLO);
    end
  endtask

  task automatic test_reset_busy;
    @(negedge clk);
    iStart = 1'b1; iMD_op = MD_MULT; iA = 32'd3; iB = 32'd4;
    @(negedge clk);
    iStart = 1'b0; iMD_op = MD_NONE;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (oHI !== 32'h0 || oLO !== 32'h0 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got HI=%h LO=%h busy=%b want 0/0/0",
               oHI, oLO, oBusy);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (oHI !== 32'h0 || oLO !== 32'h0 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL reset_nocommit got HI=%h LO=%h busy=%b want 0/0/0",
               oHI, oLO, oBusy);
    end
  endtask

  initial begin
    reset = 1'b0;
    iStart = 1'b0;
    iMD_op = MD_NONE;
    iA = '0;
    iB = '0;
    iRead_sel = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_back_to_back();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
